// File: rtl/wb_arbiter.sv
// wb_arbiter
//
// Merges two result streams onto the single register-file write port:
//   - in-order pipeline results from the WB stage (pipe_*), and
//   - out-of-order multi-cycle results (mc_*), buffered in a small FIFO.
// Exactly one write is chosen per cycle and registered into rf_*. A
// starvation counter forces the queue head through after STARVE_LIMIT
// consecutive losses to the pipeline. pending_rs1/2 tell the hazard unit
// that a register still has an uncommitted write held inside this block.
//
// Ports
//   clk                      clock, rising edge
//   reset                    asynchronous reset, active low
//   pipe_reg_write/rd/data   WB-stage write request (rd = 0 means no write)
//   pipe_stall               WB write not consumed this cycle; WB holds it
//   mc_valid/rd/data         multi-cycle result (rd = 0 is dropped)
//   mc_ready                 queue has a free slot
//   rf_write_enable/rd/din   registered register-file write port
//   query_rs1/rs2            decode-stage source registers
//   pending_rs1/rs2          queried register has an uncommitted write here
module wb_arbiter #(
   parameter int DEPTH        = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pipe_reg_write,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_data,
   output logic        pipe_stall,
   input  logic        mc_valid,
   input  logic [4:0]  mc_rd,
   input  logic [31:0] mc_data,
   output logic        mc_ready,
   output logic        rf_write_enable,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_din,
   input  logic [4:0]  query_rs1,
   input  logic [4:0]  query_rs2,
   output logic        pending_rs1,
   output logic        pending_rs2
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [4:0]       q_rd   [DEPTH];
   logic [31:0]      q_data [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [3:0]       starve_cnt;

   logic             q_nonempty;
   logic             pipe_valid;
   logic             force_pop;
   logic             pop;
   logic             take_pipe;
   logic             push;
   logic [3:0]       starve_nxt;

   // ---------------------------------------------------------------
   // Selection
   // ---------------------------------------------------------------
   assign q_nonempty = (count != '0);
   assign pipe_valid = pipe_reg_write && (pipe_rd != 5'd0);
   assign force_pop  = (starve_cnt >= 4'(STARVE_LIMIT));
   assign pop        = q_nonempty && (force_pop || !pipe_valid);
   assign take_pipe  = pipe_valid && !pop;
   assign pipe_stall = pipe_valid && pop;

   // Readiness looks at the current count only, so a same-cycle pop never
   // makes room for a same-cycle push. rd = 0 results complete the
   // handshake but are never written into the queue.
   assign mc_ready   = (count != CNT_W'(DEPTH));
   assign push       = mc_valid && mc_ready && (mc_rd != 5'd0);

   always_comb begin
      // NOTE: default assignment first so every path drives the signal and no latch is inferred.
      starve_nxt = starve_cnt;
      if (pop || !q_nonempty)
         starve_nxt = 4'd0;
      else if (take_pipe && starve_cnt != 4'hF)
         starve_nxt = starve_cnt + 4'd1;
   end

   // ---------------------------------------------------------------
   // Queue storage
   // ---------------------------------------------------------------
   // NOTE: the entry array carries no reset; validity comes solely from count and the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         q_rd[wr_ptr]   <= mc_rd;
         q_data[wr_ptr] <= mc_data;
      end
   end

   // ---------------------------------------------------------------
   // Control state and registered write port
   // ---------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         count           <= '0;
         starve_cnt      <= 4'd0;
         rf_write_enable <= 1'b0;
         rf_rd           <= 5'd0;
         rf_din          <= 32'd0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count      <= count + CNT_W'(push) - CNT_W'(pop);
         starve_cnt <= starve_nxt;

         rf_write_enable <= pop || take_pipe;
         if (pop) begin
            rf_rd  <= q_rd[rd_ptr];
            rf_din <= q_data[rd_ptr];
         end else if (take_pipe) begin
            rf_rd  <= pipe_rd;
            rf_din <= pipe_data;
         end
      end
   end

   // ---------------------------------------------------------------
   // Pending-write lookup: live queue entries plus the output register
   // ---------------------------------------------------------------
   always_comb begin
      logic [PTR_W-1:0] offs;
      offs        = '0;
      pending_rs1 = 1'b0;
      pending_rs2 = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         // An entry is live when its distance from the head is below count.
         offs = PTR_W'(i) - rd_ptr;
         if (CNT_W'(offs) < count) begin
            if (q_rd[i] == query_rs1) pending_rs1 = 1'b1;
            if (q_rd[i] == query_rs2) pending_rs2 = 1'b1;
         end
      end
      if (rf_write_enable && rf_rd == query_rs1) pending_rs1 = 1'b1;
      if (rf_write_enable && rf_rd == query_rs2) pending_rs2 = 1'b1;
      if (query_rs1 == 5'd0) pending_rs1 = 1'b0;
      if (query_rs2 == 5'd0) pending_rs2 = 1'b0;
   end

endmodule
